// File: rtl/spi_pkg.sv
// Shared types and helpers for the configurable SPI master.
// Optional feature macro: SPI_LSB_FIRST_EN (adds the lsb_first input).
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        DATA  = 2'd2,
        TRAIL = 2'd3
    } spi_state_e;

    // SPI modes encoded as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Bits needed to index n chip selects, never less than one
    function automatic int sel_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer: counts 0..div_q while enabled and strobes on the last count.
module spi_clk_gen #(
    parameter int DIV_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] div_q,
    output logic             strobe
);

    logic [DIV_W-1:0] cnt_q;

    assign strobe = en && (cnt_q == div_q);

    // Counter held at zero when disabled so every phase starts a full half period
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt_q <= '0;
        end else if (strobe) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_cfg.sv
// Configurable SPI master: generic word width, runtime divider, all four
// CPOL/CPHA modes and one-hot decoded active-low chip selects.
// Optional feature macro: SPI_LSB_FIRST_EN adds lsb_first (LSB-first framing).
module spi_master_cfg
    import spi_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int DIV_W    = 12,
    parameter  int NUM_CS   = 1,
    localparam int CS_SEL_W = sel_width(NUM_CS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DIV_W-1:0]    div,
    input  logic                cpol,
    input  logic                cpha,
    input  logic [CS_SEL_W-1:0] cs_sel,
`ifdef SPI_LSB_FIRST_EN
    input  logic                lsb_first,
`endif
    input  logic [DATA_W-1:0]   thr,
    output logic [DATA_W-1:0]   rhr,
    input  logic                start_tick,
    input  logic                last_xfer,
    output logic                txrdy_tick,
    output logic                rxrdy_tick,
    output logic                done_tick,
    output logic                busy,
    output logic                spck,
    output logic [NUM_CS-1:0]   ncs,
    output logic                mosi,
    input  logic                miso
);

    localparam int                EDGE_W    = $clog2(2 * DATA_W + 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);

    spi_state_e          state_q;
    logic [DIV_W-1:0]    div_q;
    logic                cpol_q, cpha_q;
    logic [CS_SEL_W-1:0] cs_sel_q;
    logic [DATA_W-1:0]   tx_q, rx_q, rhr_q;
    logic [EDGE_W-1:0]   edge_q;
    logic [NUM_CS-1:0]   ncs_q;
    logic                spck_q, mosi_q, busy_q;
    logic                txrdy_q, rxrdy_q, done_q;
    logic                lsb_s, strobe_s;

    logic [EDGE_W-1:0]   edge_d;
    logic [DATA_W-1:0]   tx_d, rx_d;
    logic                lead_s, last_s, sample_lead_s, sample_s, shift_s;
    logic [NUM_CS-1:0]   cs_dec_s;
    logic [CS_SEL_W-1:0] cs_idx_s;

`ifdef SPI_LSB_FIRST_EN
    logic lsb_q;
    assign lsb_s = lsb_q;
`else
    assign lsb_s = 1'b0;
`endif

    function automatic logic out_bit(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
        .clk    (clk),
        .reset  (reset),
        .en     (state_q != IDLE),
        .div_q  (div_q),
        .strobe (strobe_s)
    );

    // Next-edge decode and shift-register next values for a DATA strobe
    always_comb begin
        edge_d = edge_q + EDGE_W'(1);
        lead_s = edge_d[0];
        last_s = (edge_d == EDGE_LAST);
        case ({cpol_q, cpha_q})
            MODE0, MODE2: sample_lead_s = 1'b1;
            MODE1, MODE3: sample_lead_s = 1'b0;
            default:      sample_lead_s = 1'b1;
        endcase
        sample_s = sample_lead_s ? lead_s : ~lead_s;
        if (sample_lead_s) begin
            shift_s = ~lead_s && !last_s;
        end else begin
            shift_s = lead_s && (edge_d != EDGE_W'(1));
        end
        if (!sample_s) begin
            rx_d = rx_q;
        end else if (lsb_s) begin
            rx_d = {miso, rx_q[DATA_W-1:1]};
        end else begin
            rx_d = {rx_q[DATA_W-2:0], miso};
        end
        if (!shift_s) begin
            tx_d = tx_q;
        end else if (lsb_s) begin
            tx_d = {1'b0, tx_q[DATA_W-1:1]};
        end else begin
            tx_d = {tx_q[DATA_W-2:0], 1'b0};
        end
    end

    // One-hot chip select decode: live index in IDLE, captured index otherwise
    always_comb begin
        cs_dec_s = '0;
        if (state_q == IDLE) begin
            cs_idx_s = cs_sel;
        end else begin
            cs_idx_s = cs_sel_q;
        end
        for (int i = 0; i < NUM_CS; i++) begin
            cs_dec_s[i] = (cs_idx_s == CS_SEL_W'(i));
        end
    end

    // Transfer FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            div_q    <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            cs_sel_q <= '0;
`ifdef SPI_LSB_FIRST_EN
            lsb_q    <= 1'b0;
`endif
            tx_q     <= '0;
            rx_q     <= '0;
            rhr_q    <= '0;
            edge_q   <= '0;
            ncs_q    <= '1;
            spck_q   <= 1'b0;
            mosi_q   <= 1'b0;
            busy_q   <= 1'b0;
            txrdy_q  <= 1'b0;
            rxrdy_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            txrdy_q <= 1'b0;
            rxrdy_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    spck_q <= cpol;
                    ncs_q  <= '1;
                    if (start_tick) begin
                        div_q    <= div;
                        cpol_q   <= cpol;
                        cpha_q   <= cpha;
                        cs_sel_q <= cs_sel;
`ifdef SPI_LSB_FIRST_EN
                        lsb_q    <= lsb_first;
`endif
                        ncs_q    <= ~cs_dec_s;
                        busy_q   <= 1'b1;
                        state_q  <= LEAD;
                    end
                end
                LEAD: begin
                    ncs_q <= ~cs_dec_s;
                    if (strobe_s) begin
                        tx_q    <= thr;
                        mosi_q  <= out_bit(thr, lsb_s);
                        txrdy_q <= 1'b1;
                        edge_q  <= '0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (strobe_s) begin
                        spck_q <= ~spck_q;
                        rx_q   <= rx_d;
                        if (last_s) begin
                            rhr_q   <= rx_d;
                            rxrdy_q <= 1'b1;
                            if (last_xfer) begin
                                edge_q  <= edge_d;
                                tx_q    <= tx_d;
                                mosi_q  <= out_bit(tx_d, lsb_s);
                                state_q <= TRAIL;
                            end else begin
                                // Next word follows with no spck gap
                                edge_q  <= '0;
                                tx_q    <= thr;
                                mosi_q  <= out_bit(thr, lsb_s);
                                txrdy_q <= 1'b1;
                            end
                        end else begin
                            edge_q <= edge_d;
                            tx_q   <= tx_d;
                            mosi_q <= out_bit(tx_d, lsb_s);
                        end
                    end
                end
                TRAIL: begin
                    spck_q <= cpol_q;
                    if (strobe_s) begin
                        ncs_q   <= '1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ncs_q   <= '1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rhr        = rhr_q;
    assign txrdy_tick = txrdy_q;
    assign rxrdy_tick = rxrdy_q;
    assign done_tick  = done_q;
    assign busy       = busy_q;
    assign spck       = spck_q;
    assign ncs        = ncs_q;
    assign mosi       = mosi_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Scoreboard bench for spi_master_cfg (DATA_W=8, NUM_CS=4). Expected words are
// queued by the stimulus; a monitor pops and compares on every rxrdy_tick.
module tb_spi_master_cfg;

    localparam int LIMIT = 5000;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] div;
    logic        cpol, cpha;
    logic [1:0]  cs_sel;
    logic        lsb_first;
    logic [7:0]  thr;
    logic [7:0]  rhr;
    logic        start_tick, last_xfer;
    logic        txrdy_tick, rxrdy_tick, done_tick, busy;
    logic        spck, mosi, miso;
    logic [3:0]  ncs;

    // slave model for the mode 3 test
    logic        model_en = 1'b0;
    logic        miso_m = 1'b0;
    logic [7:0]  slv = 8'h00;

    assign miso = model_en ? miso_m : mosi;

    spi_master_cfg #(.DATA_W(8), .DIV_W(12), .NUM_CS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .div        (div),
        .cpol       (cpol),
        .cpha       (cpha),
        .cs_sel     (cs_sel),
`ifdef SPI_LSB_FIRST_EN
        .lsb_first  (lsb_first),
`endif
        .thr        (thr),
        .rhr        (rhr),
        .start_tick (start_tick),
        .last_xfer  (last_xfer),
        .txrdy_tick (txrdy_tick),
        .rxrdy_tick (rxrdy_tick),
        .done_tick  (done_tick),
        .busy       (busy),
        .spck       (spck),
        .ncs        (ncs),
        .mosi       (mosi),
        .miso       (miso)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] sb[$];
    logic [7:0] words [0:3];

    // monitor statistics
    int n_txrdy, n_rxrdy, n_done, rises, toggles, max_gap, since, bad_mosi;
    int ncs_low [0:3];
    logic seen, fell, prev_spck, prev_mosi;
    logic [7:0] mosi_hist;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        n_txrdy = 0; n_rxrdy = 0; n_done = 0; rises = 0; toggles = 0;
        max_gap = 0; since = 0; bad_mosi = 0; seen = 1'b0; fell = 1'b0;
        mosi_hist = 8'h00; prev_spck = spck; prev_mosi = mosi;
        for (int i = 0; i < 4; i++) ncs_low[i] = 0;
    endtask

    // slave shifts out MSB first on each falling spck while selected
    always @(negedge spck) begin
        if (model_en && ncs[0] == 1'b0) begin
            miso_m = slv[7];
            slv = {slv[6:0], 1'b0};
        end
    end

    // monitor: scoreboard compare on rxrdy and pin statistics
    always @(negedge clk) begin
        if (txrdy_tick) n_txrdy++;
        if (done_tick) n_done++;
        if (rxrdy_tick) begin
            n_rxrdy++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: rhr %0h with no expected word", rhr);
            end else begin
                check("sb_rhr", {24'h0, rhr}, {24'h0, sb.pop_front()});
            end
        end
        for (int i = 0; i < 4; i++) if (ncs[i] == 1'b0) ncs_low[i]++;
        if (mosi !== prev_mosi && fell && !(prev_spck && !spck)) bad_mosi++;
        if (spck !== prev_spck) begin
            toggles++;
            if (seen && since > max_gap) max_gap = since;
            since = 0;
            seen = 1'b1;
            if (spck) begin
                rises++;
                mosi_hist = {mosi_hist[6:0], mosi};
            end else begin
                fell = 1'b1;
            end
        end
        since++;
        prev_spck = spck;
        prev_mosi = mosi;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic pol, input logic pha, input logic [11:0] d,
                             input logic [1:0] sel, input int n, input logic poke);
        int guard;
        logic [3:0] exp_ncs;
        cpol = pol; cpha = pha; div = d; cs_sel = sel;
        thr = words[0]; last_xfer = (n == 1);
        repeat (3) tick();
        clear_stats();
        start_tick = 1'b1;
        tick();
        start_tick = 1'b0;
        exp_ncs = 4'hF;
        exp_ncs[sel] = 1'b0;
        check("ncs_latency", {28'h0, ncs}, {28'h0, exp_ncs});
        for (int i = 0; i < n; i++) begin
            guard = 0;
            while (!txrdy_tick && guard < LIMIT) begin
                tick();
                guard++;
            end
            if (guard >= LIMIT) begin
                tests++; fails++;
                $display("FAIL txrdy_timeout: word %0d not requested in %0d cycles", i, LIMIT);
            end
            last_xfer = (i == n - 1);
            if (i < n - 1) thr = words[i + 1];
            if (poke && i == 0) start_tick = 1'b1;
            tick();
            start_tick = 1'b0;
        end
        guard = 0;
        while (!done_tick && guard < LIMIT) begin
            tick();
            guard++;
        end
        if (guard >= LIMIT) begin
            tests++; fails++;
            $display("FAIL done_timeout: no done_tick in %0d cycles", LIMIT);
        end
        check("busy_at_done", {31'h0, busy}, 32'h0);
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        reset = 1'b1; div = 12'd0; cpol = 1'b0; cpha = 1'b0; cs_sel = 2'd0;
        lsb_first = 1'b0; thr = 8'h00; start_tick = 1'b0; last_xfer = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        // reset values (still in the cycle right after the reset edge)
        check("rst_ncs", {28'h0, ncs}, 32'hF);
        check("rst_spck", {31'h0, spck}, 32'h0);
        check("rst_mosi", {31'h0, mosi}, 32'h0);
        check("rst_rhr", {24'h0, rhr}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_ticks", {29'h0, txrdy_tick, rxrdy_tick, done_tick}, 32'h0);

        // mode 0, div 1, loopback 0xA5
        words[0] = 8'hA5; sb.push_back(8'hA5);
        run_frame(1'b0, 1'b0, 12'd1, 2'd0, 1, 1'b0);
        check("m0_rises", rises, 8);
        check("m0_ncs_low", ncs_low[0], 36);
        check("m0_done", n_done, 1);
        check("m0_mosi_bits", {24'h0, mosi_hist}, 32'hA5);

        // mode 3, div 0, slave model returns 0xC3
        cpol = 1'b1; cpha = 1'b1;
        repeat (3) tick();
        check("m3_idle_high_before", {31'h0, spck}, 32'h1);
        model_en = 1'b1; slv = 8'hC3;
        words[0] = 8'h3C; sb.push_back(8'hC3);
        run_frame(1'b1, 1'b1, 12'd0, 2'd0, 1, 1'b0);
        check("m3_idle_high_after", {31'h0, spck}, 32'h1);
        check("m3_mosi_on_fall", bad_mosi, 0);
        check("m3_rises", rises, 8);
        check("m3_mosi_bits", {24'h0, mosi_hist}, 32'h3C);
        model_en = 1'b0;

        // back-to-back words, mode 0, div 1
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h33);
        run_frame(1'b0, 1'b0, 12'd1, 2'd0, 3, 1'b0);
        check("b2b_txrdy", n_txrdy, 3);
        check("b2b_rxrdy", n_rxrdy, 3);
        check("b2b_done", n_done, 1);
        check("b2b_max_gap", max_gap, 2);
        check("b2b_ncs_low", ncs_low[0], 100);

        // chip select 2 with an ignored second start
        words[0] = 8'h5A; sb.push_back(8'h5A);
        run_frame(1'b0, 1'b0, 12'd0, 2'd2, 1, 1'b1);
        repeat (40) tick();
        check("cs2_low", ncs_low[2], 18);
        check("cs2_others", ncs_low[0] + ncs_low[1] + ncs_low[3], 0);
        check("cs2_done", n_done, 1);
        check("cs2_idle", {31'h0, busy}, 32'h0);

        // reset at edge 5 of a word
        cpol = 1'b0; cpha = 1'b0; div = 12'd1; cs_sel = 2'd1;
        thr = 8'hFF; last_xfer = 1'b1;
        repeat (3) tick();
        clear_stats();
        start_tick = 1'b1;
        tick();
        start_tick = 1'b0;
        guard = 0;
        while (toggles < 4 && guard < LIMIT) begin
            tick();
            guard++;
        end
        if (guard >= LIMIT) begin
            tests++; fails++;
            $display("FAIL edge_timeout: spck toggles %0d, required 4", toggles);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_ncs", {28'h0, ncs}, 32'hF);
        check("abort_spck", {31'h0, spck}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        repeat (10) tick();
        check("abort_done", n_done, 0);
        check("abort_rxrdy", n_rxrdy, 0);
        words[0] = 8'h96; sb.push_back(8'h96);
        run_frame(1'b0, 1'b0, 12'd1, 2'd1, 1, 1'b0);
        check("fresh_done", n_done, 1);
        check("fresh_ncs_low", ncs_low[1], 36);

`ifdef SPI_LSB_FIRST_EN
        lsb_first = 1'b1;
        words[0] = 8'h01; sb.push_back(8'h01);
        run_frame(1'b0, 1'b0, 12'd1, 2'd0, 1, 1'b0);
        check("lsb_mosi_bits", {24'h0, mosi_hist}, 32'h80);
        lsb_first = 1'b0;
`endif

        repeat (5) tick();
        check("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_master_cfg.md
Name: spi_master_cfg

Overview:
Parametrised successor SPI master with generic word width, runtime clock divider, all four SPI modes (CPOL/CPHA), and NUM_CS one-hot-decoded chip selects. It sits between a byte/word host (UART bridge, register block) and external SPI peripherals. It keeps the start_tick/last_xfer/txrdy/rxrdy/done tick handshake style, so existing hosts port with only width changes.

Parameters:
DATA_W, 8, bits per SPI word.
DIV_W, 12, width of runtime divider input.
NUM_CS, 1, number of active-low chip selects; CS_SEL_W = max(1, clog2(NUM_CS)) is a localparam.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
div  in  DIV_W  half-period of spck = div+1 clk cycles; captured at start
cpol  in  1  idle spck level; captured at start
cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; captured at start
cs_sel  in  CS_SEL_W  chip select index; captured at start
thr  in  DATA_W  transmit word
rhr  out  DATA_W  last received word
start_tick  in  1  begin transfer (honoured only in IDLE)
last_xfer  in  1  sampled at word end; 1 = stop after this word
txrdy_tick  out  1  one-cycle pulse; thr captured, host may present next word
rxrdy_tick  out  1  one-cycle pulse; rhr holds new word this cycle
done_tick  out  1  one-cycle pulse; ncs released
busy  out  1  state != IDLE
spck  out  1  SPI clock
ncs  out  NUM_CS  active-low chip selects
mosi  out  1  serial out, MSB first
miso  in  1  serial in

Behaviour:
- Clock/reset: single clk. Reset is synchronous and active-high. All ticks and ncs are registered.
- Reset values: state IDLE, ncs all 1, spck = 0, mosi = 0, rhr = 0, all ticks 0, busy 0.
- Reset mid-transfer returns to IDLE on the same edge. ncs goes high and spck returns to idle. No done_tick or rxrdy_tick is issued.
- Half-period timer: counts 0..div_q, then emits a half-period strobe and reloads. div = 0 gives a 1-cycle half period.
- IDLE: spck = live cpol, ncs all 1. On start_tick, capture div/cpol/cpha/cs_sel into _q registers, clear the timer, and go to LEAD.
- LEAD (one half period): ncs[cs_sel_q] = 0. On the strobe, tx_reg <= thr, txrdy_tick <= 1, edge counter <= 0, go to DATA.
- DATA: each strobe toggles spck and increments the edge counter over 1..2*DATA_W. Odd edges are leading edges; even edges are trailing edges.
- Sampling: rx_reg shifts in miso on leading edges when cpha = 0, and on trailing edges when cpha = 1.
- Shifting: tx_reg shifts on trailing edges except edge 2*DATA_W when cpha = 0. When cpha = 1 it shifts on leading edges except edge 1. mosi = tx_reg[DATA_W-1].
- Edge 2*DATA_W: rhr <= completed word and rxrdy_tick <= 1.
  - If last_xfer = 1 that cycle, go to TRAIL.
  - Otherwise tx_reg <= thr, txrdy_tick <= 1, edge counter <= 0, and stay in DATA. Words run back-to-back with no spck gap.
- TRAIL (one half period): spck = cpol_q, ncs held low. On the strobe, ncs goes all 1, done_tick <= 1, go to IDLE.
- start_tick outside IDLE is ignored. Config input changes during a transfer have no effect.
- cs_sel >= NUM_CS: no ncs line asserts, but the transfer clocks normally.
- Latency: start_tick to ncs low is 1 cycle. A word occupies 2*DATA_W*(div+1) cycles. Total single-word frame: (2*DATA_W+2)*(div+1) cycles.

Optional Feature:
SPI_LSB_FIRST_EN.
- Defined: adds input lsb_first, captured at start. When 1, tx_reg shifts right, mosi = tx_reg[0], and rx_reg fills from the MSB downward so rhr is bit-correct.
- Undefined: no lsb_first port; MSB-first only.

Decomposition:
- Package spi_pkg holds:
  - state encoding IDLE/LEAD/DATA/TRAIL;
  - mode constants MODE0..MODE3 as {cpol,cpha};
  - a clog2-style helper for CS_SEL_W.
- Sub-module spi_clk_gen: half-period counter with inputs clk, reset, en, div_q and output strobe.

Test Plan:
- Mode 0, div = 1, DATA_W = 8, miso looped to mosi, thr = 0xA5, last_xfer = 1 -> rhr = 0xA5. Exactly 8 spck rising edges, ncs[0] low for 36 cycles, one done_tick.
- Mode 3, div = 0, thr = 0x3C, miso driven from a model returning 0xC3 -> rhr = 0xC3. spck idles high before and after. mosi changes only on falling spck.
- Back-to-back: 3 words 0x11, 0x22, 0x33 with last_xfer on the third -> 3 txrdy_tick, 3 rxrdy_tick, 1 done_tick. No spck gap between words, and ncs stays low throughout.
- NUM_CS = 4, cs_sel = 2 -> only ncs[2] asserts. A second start_tick while busy is ignored, with no extra done_tick.
- Reset asserted at edge 5 of a word -> next cycle ncs = 4'hF, spck = cpol, busy = 0, no done_tick. A fresh transfer afterwards completes correctly.
- With SPI_LSB_FIRST_EN, lsb_first = 1, thr = 0x01, loopback -> mosi is high on the first bit only, and rhr = 0x01.
